// File: rtl/nv_nvdla_hls_shiftleftsat_pipe.sv
// nv_nvdla_hls_shiftleftsat_pipe
// Two-stage signed left shift with saturation, widening IN_WIDTH to OUT_WIDTH.
// S1 holds operand, shift and a precomputed overflow flag; S2 holds the
// final result. A saturating counter tracks how many clipped results left.
module nv_nvdla_hls_shiftleftsat_pipe #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   in_pvld,
    output logic                   in_prdy,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    output logic                   out_pvld,
    input  logic                   out_prdy,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    input  logic                   sat_cnt_clr,
    output logic [CNT_WIDTH-1:0]   sat_cnt
);

    localparam int STAGES = 2;
    localparam logic [31:0] OW = 32'(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // valid bit per stage: [1] = S1, [2] = S2 (drives out_pvld)
    logic [STAGES:1]        vld_pipe_q, vld_pipe_d;
    logic [IN_WIDTH-1:0]    s1_data_q, s1_data_d;
    logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
    logic                   s1_ovf_q, s1_ovf_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

    logic                   s1_adv, s2_adv;
    logic [OUT_WIDTH-1:0]   in_ext, ovf_mask;
    logic                   in_big_shift, in_ovf;
    logic [OUT_WIDTH-1:0]   s1_ext, s2_res;

    // Overflow check on the sign-extended input: the bits that get shifted
    // through the result MSB, plus the MSB itself, must all match the sign.
    always_comb begin
        in_ext       = OUT_WIDTH'($signed(in_data));
        in_big_shift = (32'(in_shift) >= OW);
        ovf_mask     = '1;
        if (!in_big_shift)
            ovf_mask = {OUT_WIDTH{1'b1}} << (OW - 32'd1 - 32'(in_shift));
        if (in_big_shift)
            in_ovf = |in_data;
        else
            in_ovf = |((in_ext ^ {OUT_WIDTH{in_data[IN_WIDTH-1]}}) & ovf_mask);
    end

    // Handshake: each stage advances when empty or when downstream advances.
    always_comb begin
        s2_adv  = ~vld_pipe_q[2] | out_prdy;
        s1_adv  = ~vld_pipe_q[1] | s2_adv;
        in_prdy = s1_adv;
    end

    // S2 result: clip by sign on overflow, otherwise the plain shift is exact.
    always_comb begin
        s1_ext = OUT_WIDTH'($signed(s1_data_q));
        if (s1_ovf_q)
            s2_res = s1_data_q[IN_WIDTH-1] ? MIN_NEG : MAX_POS;
        else
            s2_res = s1_ext << s1_shift_q;
    end

    // Next state for the valid shift register, stage data and sat counter.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_data_d  = s1_data_q;
        s1_shift_d = s1_shift_q;
        s1_ovf_d   = s1_ovf_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        sat_cnt_d  = sat_cnt_q;

        if (s1_adv) begin
            vld_pipe_d[1] = in_pvld;
            if (in_pvld) begin
                s1_data_d  = in_data;
                s1_shift_d = in_shift;
                s1_ovf_d   = in_ovf;
            end
        end
        if (s2_adv) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                out_data_d = s2_res;
                out_sat_d  = s1_ovf_q;
            end
        end

        if (sat_cnt_clr)
            sat_cnt_d = '0;
        else if (vld_pipe_q[2] && out_prdy && out_sat_q && !(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
    end

    // State registers; async reset empties the pipe and zeroes the counter.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_pipe_q <= '0;
            s1_data_q  <= '0;
            s1_shift_q <= '0;
            s1_ovf_q   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_data_q  <= s1_data_d;
            s1_shift_q <= s1_shift_d;
            s1_ovf_q   <= s1_ovf_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign out_pvld = vld_pipe_q[STAGES];
    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;
    assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_hls_shiftleftsat_pipe.sv
// Scoreboard bench for nv_nvdla_hls_shiftleftsat_pipe. A second instance with
// a 2-bit counter shares all inputs so counter saturation is reachable.
module tb_nv_nvdla_hls_shiftleftsat_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_pvld, in_prdy, in_prdy_n;
    logic [15:0] in_data;
    logic [5:0]  in_shift;
    logic        out_pvld, out_pvld_n, out_prdy;
    logic [31:0] out_data, out_data_n;
    logic        out_sat, out_sat_n;
    logic        sat_cnt_clr;
    logic [31:0] sat_cnt;
    logic [1:0]  sat_cnt_n;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int c0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nv_nvdla_hls_shiftleftsat_pipe u_dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_pvld(in_pvld), .in_prdy(in_prdy), .in_data(in_data), .in_shift(in_shift),
        .out_pvld(out_pvld), .out_prdy(out_prdy), .out_data(out_data), .out_sat(out_sat),
        .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt)
    );

    nv_nvdla_hls_shiftleftsat_pipe #(.CNT_WIDTH(2)) u_dut_n (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_pvld(in_pvld), .in_prdy(in_prdy_n), .in_data(in_data), .in_shift(in_shift),
        .out_pvld(out_pvld_n), .out_prdy(out_prdy), .out_data(out_data_n), .out_sat(out_sat_n),
        .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one element, push its expected result at the accepting cycle.
    task automatic send(input logic [15:0] d, input logic [5:0] s,
                        input logic [31:0] ed, input logic es);
        bit acc = 0;
        in_pvld  = 1'b1;
        in_data  = d;
        in_shift = s;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_prdy) begin
                sb.push_back({ed, es});
                acc = 1;
            end
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_pvld = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_pvld) done = 1;
        end
        chk("drain", 64'(done), 1);
        @(posedge clk); #1;
    endtask

    // Pops on every output transfer; also checks outputs hold under stall.
    task automatic monitor();
        exp_t        e;
        bit          hold = 0;
        logic [31:0] hd;
        logic        hs;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold_data", 64'(out_data), 64'(hd));
                    chk("hold_sat", 64'(out_sat), 64'(hs));
                end
                if (out_pvld && out_prdy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'(out_data), 64'(e.d));
                        chk("out_sat", 64'(out_sat), 64'(e.s));
                        chk("out_data_n", 64'(out_data_n), 64'(e.d));
                        chk("out_sat_n", 64'(out_sat_n), 64'(e.s));
                        last_pop_cyc = cyc;
                    end
                end
                hold = out_pvld && !out_prdy;
                hd   = out_data;
                hs   = out_sat;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rstn = 1'b0; in_pvld = 1'b0; in_data = '0; in_shift = '0;
        out_prdy = 1'b1; sat_cnt_clr = 1'b0;
        fork monitor(); join_none

        repeat (3) @(posedge clk); #1;
        chk("rst_pvld", 64'(out_pvld), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_sat", 64'(out_sat), 0);
        chk("rst_cnt", 64'(sat_cnt), 0);
        chk("rst_cnt_n", 64'(sat_cnt_n), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_prdy", 64'(in_prdy), 1);
        @(posedge clk); #1;

        // counter: preload narrow counter to all-ones minus 1, then saturate
        send(16'h7FFF, 6'd17, 32'h7FFFFFFF, 1'b1);
        send(16'h0001, 6'd31, 32'h7FFFFFFF, 1'b1);
        drain();
        chk("cnt_two", 64'(sat_cnt), 2);
        chk("cnt_n_two", 64'(sat_cnt_n), 2);
        send(16'h8000, 6'd17, 32'h80000000, 1'b1);
        send(16'hFFFF, 6'd40, 32'h80000000, 1'b1);
        drain();
        chk("cnt_four", 64'(sat_cnt), 4);
        chk("cnt_n_sat", 64'(sat_cnt_n), 3);

        // clear in the same cycle as a saturating transfer
        out_prdy = 1'b0;
        send(16'h0001, 6'd40, 32'h7FFFFFFF, 1'b1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_pvld) seen = 1;
        end
        chk("clr_hold_pvld", 64'(seen), 1);
        @(posedge clk); #1;
        out_prdy = 1'b1; sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("clr_cnt", 64'(sat_cnt), 0);
        chk("clr_cnt_n", 64'(sat_cnt_n), 0);
        drain();

        // latency: valid appears in the second cycle after the accept cycle
        send(16'h0003, 6'd4, 32'h00000030, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", 64'(out_pvld), 0);
        @(negedge clk);
        chk("lat_cycle2", 64'(out_pvld), 1);
        @(posedge clk); #1;

        // back-to-back directed limits
        send(16'h7FFF, 6'd16, 32'h7FFF0000, 1'b0);
        send(16'h8000, 6'd16, 32'h80000000, 1'b0);
        send(16'hFFFF, 6'd31, 32'h80000000, 1'b0);
        send(16'h0000, 6'd63, 32'h00000000, 1'b0);
        send(16'hFFFD, 6'd2,  32'hFFFFFFF4, 1'b0);
        send(16'h1234, 6'd0,  32'h00001234, 1'b0);
        send(16'h0001, 6'd32, 32'h7FFFFFFF, 1'b1);
        send(16'h4000, 6'd17, 32'h7FFFFFFF, 1'b1);
        send(16'hC000, 6'd17, 32'h80000000, 1'b0);
        send(16'h4000, 6'd16, 32'h40000000, 1'b0);
        drain();
        chk("cnt_stream", 64'(sat_cnt), 2);
        chk("cnt_n_stream", 64'(sat_cnt_n), 2);

        // backpressure: two accepted, then ready stays low while stalled
        out_prdy = 1'b0;
        send(16'h0010, 6'd1, 32'h00000020, 1'b0);
        send(16'h7FFF, 6'd20, 32'h7FFFFFFF, 1'b1);
        in_pvld = 1'b1; in_data = 16'hFFF0; in_shift = 6'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_prdy", 64'(in_prdy), 0);
            chk("stall_prdy_n", 64'(in_prdy_n), 0);
            chk("stall_pvld", 64'(out_pvld), 1);
        end
        chk("stall_accepted", 64'(sb.size()), 2);
        @(posedge clk); #1;
        out_prdy = 1'b1;
        c0 = cyc;
        send(16'hFFF0, 6'd3,  32'hFFFFFF80, 1'b0);
        send(16'h8001, 6'd16, 32'h80010000, 1'b0);
        drain();
        chk("stall_drain_cycle", 64'(last_pop_cyc), 64'(c0 + 3));
        chk("cnt_stall", 64'(sat_cnt), 3);
        chk("cnt_n_stall", 64'(sat_cnt_n), 3);

        // async reset with elements in flight
        send(16'h7FFF, 6'd31, 32'h7FFFFFFF, 1'b1);
        send(16'h0001, 6'd63, 32'h7FFFFFFF, 1'b1);
        @(posedge clk); #2;
        chk("pre_rst_cnt", 64'(sat_cnt), 4);
        chk("pre_rst_pvld", 64'(out_pvld), 1);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_pvld", 64'(out_pvld), 0);
        chk("async_rst_pvld_n", 64'(out_pvld_n), 0);
        chk("async_rst_cnt", 64'(sat_cnt), 0);
        chk("async_rst_cnt_n", 64'(sat_cnt_n), 0);
        sb.delete();
        repeat (2) @(posedge clk); #2;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_pvld", 64'(out_pvld), 0);
        end
        @(posedge clk); #1;
        send(16'h0005, 6'd1, 32'h0000000A, 1'b0);
        drain();
        chk("post_rst_cnt", 64'(sat_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
